lcd16x2_ctrl: RTL and testbench
===============================

# lcd16x2_ctrl

Character-LCD write controller for an HD44780-compatible 16x2 module in 8-bit parallel mode. After reset it runs the controller power-up/initialisation sequence on its own. It then accepts one command or character write at a time from a client state machine through an enable/ready handshake. It generates the RS/E/DB bus timing and the required execution delays, and sits between application logic (e.g. a text printer) and the FPGA pins.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: clock frequency; all delays derive from it.
- `POWERUP_US`, default 20000: power-up wait before the first init command; a bench may shorten it.
- `clk_i` input, 1 bit: single clock; all logic on rising edge.
- `rst_i` input, 1 bit: reset, synchronous and active-high. It restarts the whole init sequence.
- `data_i` input, 8 bits: command byte or character code.
- `ops_i` input, 2 bits: operation select, 0=command, 1=character, 2=clear, 3=home.
- `enb_i` input, 1 bit: request; sampled only while `rdy_o`=1.
- `rdy_o` output, 1 bit: 1 only when idle and able to accept a request.
- `lcd_rs_o` output, 1 bit: register select, 0=instruction, 1=data.
- `lcd_e_o` output, 1 bit: enable strobe.
- `lcd_data_o` output, 8 bits: DB7..DB0.

## Operation
- Reset values of outputs: `rdy_o`=0, `lcd_e_o`=0, `lcd_rs_o`=0, `lcd_data_o`=0x00. The state becomes POWERUP.
- State machine: POWERUP → INIT → IDLE → SETUP → PULSE → HOLD → EXEC. INIT also cycles through SETUP/PULSE/HOLD/EXEC for each byte.
- **POWERUP:** wait POWERUP_US, then go to INIT.
- **INIT:** issue these bytes with RS=0 and the listed delays after each:
  - 0x38, 4.1 ms
  - 0x38, 100 µs
  - 0x38, T_EXEC
  - 0x0C, T_EXEC
  - 0x01, T_LONG
  - 0x06, T_EXEC
  - After the last byte, go to IDLE.
- **IDLE:** `rdy_o`=1 and `lcd_e_o`=0. If `enb_i`=1 on a clock edge, latch `data_i` and `ops_i`, go to SETUP, and set `rdy_o`=0 from the next cycle.
- **Byte and RS per operation:**
  - ops 0: byte = latched data, RS=0.
  - ops 1: byte = latched data, RS=1.
  - ops 2: byte = 0x01, RS=0; `data_i` ignored.
  - ops 3: byte = 0x02, RS=0; `data_i` ignored.
- **Execution delay:** T_LONG applies to ops 2, ops 3, and ops 0 with byte 0x01–0x03. All other writes use T_EXEC.
- **SETUP:** drive RS and DB with `lcd_e_o`=0 for T_SU cycles.
- **PULSE:** `lcd_e_o`=1 for T_PW cycles.
- **HOLD:** `lcd_e_o`=0, with RS and DB held, for T_H cycles.
- **EXEC:** wait the execution delay, then return to IDLE (or to the next INIT step).
- **Level-sensitive enable:** if `enb_i` is still 1 when IDLE is re-entered, a new write is accepted. Clients drop `enb_i` after seeing `rdy_o` fall.
- **Request/state isolation:** `ops_i`/`data_i` changes while busy have no effect. `enb_i` during POWERUP/INIT is ignored and not queued.
- `lcd_rs_o`/`lcd_data_o` keep the last written values while idle.

## Timing
- Cycle counts are ceil(time × CLK_FREQ_HZ), minimum 1:
  - T_SU = 60 ns
  - T_PW = 500 ns
  - T_H = 20 ns
  - T_EXEC = 50 µs
  - T_LONG = 2 ms
- At 100 MHz: T_SU=6, T_PW=50, T_H=2, T_EXEC=5000, T_LONG=200000.
- Request sampled at edge t:
  - `rdy_o`=0 and bus driven from t+1.
  - `lcd_e_o` rises at t+1+T_SU and falls after T_PW cycles high.
  - `rdy_o` returns to 1 at t+1+T_SU+T_PW+T_H+delay.
- Counters are wide enough for the larger of POWERUP_US and T_LONG with no wrap; size them with `$clog2`.
- `rst_i` asserted in any state, including mid-pulse, wins on that edge: all outputs return to reset values and POWERUP restarts.

## Structure
- Package `lcd16x2_pkg`: ops encoding (OP_CMD=0, OP_CHAR=1, OP_CLEAR=2, OP_HOME=3), state enum, and init-command constants 0x38/0x0C/0x01/0x06/0x02. The package also holds the ns/µs-to-cycles conversion function.
- One sub-module, `lcd_delay_timer`: a loadable down-counter that reports done. The FSM loads it for every wait.

## Test plan
All scenarios at 100 MHz with POWERUP_US=100.
- **Reset/init:** assert `rst_i` for 3 cycles → outputs all 0 and `rdy_o`=0. E pulses carry DB 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0, each E high 50 cycles. `rdy_o` rises only after the final 5000-cycle wait.
- **Character write:** ops=1, data=0x48, with `enb_i` held until `rdy_o` falls.
  - RS=1 and DB=0x48 at t+1.
  - E high over cycles t+7..t+56.
  - `rdy_o`=1 at t+5059.
- **Clear:** ops=2 with data=0xFF → DB=0x01, RS=0, `rdy_o` low for 200058 cycles.
- **Sequence:** write "HELLO WORLD" (11 chars) with the drop-enable handshake → exactly 11 RS=1 E pulses with DB 0x48 0x45 0x4C 0x4C 0x4F 0x20 0x57 0x4F 0x52 0x4C 0x44.
- **Reset mid-pulse:** assert `rst_i` while `lcd_e_o`=1 → E=0 next cycle, `rdy_o`=0, and the init sequence replays from 0x38.
- **Held enable:** keep `enb_i`=1 continuously with ops=1, data=0x41 → back-to-back writes; exactly one cycle of `rdy_o`=1 between them.

Source files
------------

// File: rtl/lcd16x2_pkg.sv
// lcd16x2_pkg
// Shared definitions for the HD44780 16x2 character-LCD write controller:
//   - client operation encoding (ops_i)
//   - controller state encoding
//   - HD44780 instruction bytes used by the init sequence and by clear/home
//   - time-to-cycles conversion used to derive every delay from the clock rate
package lcd16x2_pkg;

    typedef enum logic [1:0] {
        OP_CMD   = 2'd0,
        OP_CHAR  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_HOME  = 2'd3
    } lcd_op_e;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_IDLE    = 3'd2,
        ST_SETUP   = 3'd3,
        ST_PULSE   = 3'd4,
        ST_HOLD    = 3'd5,
        ST_EXEC    = 3'd6
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_HOME     = 8'h02;

    // Index of the final byte of the power-up init sequence.
    localparam logic [2:0] INIT_LAST = 3'd5;

    // ceil(t_ns * clk_hz / 1e9), never less than one cycle.
    function automatic logic [63:0] ns_to_cycles(input logic [63:0] t_ns,
                                                 input logic [63:0] clk_hz);
        logic [63:0] c;
        c = (t_ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
        if (c == 64'd0) begin
            c = 64'd1;
        end
        return c;
    endfunction

    function automatic logic [63:0] us_to_cycles(input logic [63:0] t_us,
                                                 input logic [63:0] clk_hz);
        return ns_to_cycles(t_us * 64'd1000, clk_hz);
    endfunction

    function automatic logic [63:0] max64(input logic [63:0] a, input logic [63:0] b);
        return (a > b) ? a : b;
    endfunction

    // Byte issued at each step of the init sequence.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0, 3'd1, 3'd2: b = CMD_FUNC_SET;
            3'd3:             b = CMD_DISP_ON;
            3'd4:             b = CMD_CLEAR;
            default:          b = CMD_ENTRY;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer
// Loadable down-counter. Loading N makes o_done rise after exactly N cycles,
// so a state that loads the timer on entry and leaves on o_done lasts N
// cycles. The owner loads it while in reset, so it needs no reset of its own.
// Ports:
//   i_clk   : clock, rising edge
//   i_load  : load i_count this edge (takes priority over counting)
//   i_count : cycle count to wait, must be >= 1
//   o_done  : count exhausted
module lcd_delay_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // Storing N-1 lets the zero test serve directly as the done flag.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_cnt <= i_count - CNT_W'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd16x2_ctrl.sv
// lcd16x2_ctrl
// HD44780 16x2 character-LCD write controller, 8-bit parallel mode.
// Runs the power-up init sequence by itself after reset, then accepts one
// command/character write at a time and generates RS/E/DB timing plus the
// controller execution delay.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, restarts the init sequence
//   data_i     : command byte or character code
//   ops_i      : 0=command, 1=character, 2=clear, 3=home
//   enb_i      : write request, sampled only while rdy_o=1
//   rdy_o      : idle and able to accept a request
//   lcd_rs_o   : register select (0=instruction, 1=data)
//   lcd_e_o    : enable strobe
//   lcd_data_o : DB7..DB0
module lcd16x2_ctrl #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned POWERUP_US  = 20000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic [1:0] ops_i,
    input  logic       enb_i,
    output logic       rdy_o,
    output logic       lcd_rs_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_data_o
);

    import lcd16x2_pkg::*;

    localparam logic [63:0] C_CLK   = 64'(CLK_FREQ_HZ);
    localparam logic [63:0] C_SU    = ns_to_cycles(64'd60, C_CLK);
    localparam logic [63:0] C_PW    = ns_to_cycles(64'd500, C_CLK);
    localparam logic [63:0] C_H     = ns_to_cycles(64'd20, C_CLK);
    localparam logic [63:0] C_EXEC  = us_to_cycles(64'd50, C_CLK);
    localparam logic [63:0] C_LONG  = us_to_cycles(64'd2000, C_CLK);
    localparam logic [63:0] C_4100  = us_to_cycles(64'd4100, C_CLK);
    localparam logic [63:0] C_100   = us_to_cycles(64'd100, C_CLK);
    localparam logic [63:0] C_PU    = us_to_cycles(64'(POWERUP_US), C_CLK);
    localparam int          CNT_W   = $clog2(max64(max64(C_PU, C_4100), C_LONG) + 64'd1);

    lcd_state_e       r_state;
    lcd_state_e       w_state_nx;
    logic [2:0]       r_init_idx;
    logic [2:0]       w_init_idx_nx;
    logic             r_in_init;
    logic             w_in_init_nx;
    logic             r_rs;
    logic             w_rs_nx;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nx;

    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic [CNT_W-1:0] w_exec_val;
    logic             w_tmr_done;

    lcd_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (clk_i),
        .i_load  (w_tmr_load),
        .i_count (w_tmr_val),
        .o_done  (w_tmr_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_POWERUP;
            r_init_idx <= 3'd0;
            r_in_init  <= 1'b1;
            r_rs       <= 1'b0;
            r_data     <= 8'h00;
        end else begin
            r_state    <= w_state_nx;
            r_init_idx <= w_init_idx_nx;
            r_in_init  <= w_in_init_nx;
            r_rs       <= w_rs_nx;
            r_data     <= w_data_nx;
        end
    end

    // Execution delay of the byte currently on the bus. The first two init
    // writes need the datasheet's extended waits; afterwards clear/home
    // (instruction bytes 0x01..0x03) need the long delay.
    always_comb begin
        w_exec_val = CNT_W'(C_EXEC);
        if (r_in_init) begin
            case (r_init_idx)
                3'd0:    w_exec_val = CNT_W'(C_4100);
                3'd1:    w_exec_val = CNT_W'(C_100);
                3'd4:    w_exec_val = CNT_W'(C_LONG);
                default: w_exec_val = CNT_W'(C_EXEC);
            endcase
        end else if (!r_rs && r_data >= 8'h01 && r_data <= 8'h03) begin
            w_exec_val = CNT_W'(C_LONG);
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_init_idx_nx = r_init_idx;
        w_in_init_nx  = r_in_init;
        w_rs_nx       = r_rs;
        w_data_nx     = r_data;
        case (r_state)
            ST_POWERUP: begin
                if (w_tmr_done) begin
                    w_state_nx = ST_INIT;
                end
            end
            ST_INIT: begin
                w_rs_nx    = 1'b0;
                w_data_nx  = init_byte(r_init_idx);
                w_state_nx = ST_SETUP;
            end
            ST_IDLE: begin
                if (enb_i) begin
                    w_state_nx = ST_SETUP;
                    case (lcd_op_e'(ops_i))
                        OP_CMD: begin
                            w_rs_nx   = 1'b0;
                            w_data_nx = data_i;
                        end
                        OP_CHAR: begin
                            w_rs_nx   = 1'b1;
                            w_data_nx = data_i;
                        end
                        OP_CLEAR: begin
                            w_rs_nx   = 1'b0;
                            w_data_nx = CMD_CLEAR;
                        end
                        OP_HOME: begin
                            w_rs_nx   = 1'b0;
                            w_data_nx = CMD_HOME;
                        end
                    endcase
                end
            end
            ST_SETUP: begin
                if (w_tmr_done) begin
                    w_state_nx = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (w_tmr_done) begin
                    w_state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_tmr_done) begin
                    w_state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_tmr_done) begin
                    if (!r_in_init) begin
                        w_state_nx = ST_IDLE;
                    end else if (r_init_idx == INIT_LAST) begin
                        w_in_init_nx = 1'b0;
                        w_state_nx   = ST_IDLE;
                    end else begin
                        w_init_idx_nx = r_init_idx + 3'd1;
                        w_state_nx    = ST_INIT;
                    end
                end
            end
            default: begin
                w_state_nx = ST_POWERUP;
            end
        endcase
    end

    // Every timed state loads its duration on entry; reset loads the
    // power-up wait so POWERUP starts counting on the reset edge itself.
    always_comb begin
        w_tmr_load = rst_i || (w_state_nx != r_state);
        case (w_state_nx)
            ST_POWERUP: w_tmr_val = CNT_W'(C_PU);
            ST_SETUP:   w_tmr_val = CNT_W'(C_SU);
            ST_PULSE:   w_tmr_val = CNT_W'(C_PW);
            ST_HOLD:    w_tmr_val = CNT_W'(C_H);
            ST_EXEC:    w_tmr_val = w_exec_val;
            default:    w_tmr_val = CNT_W'(1);
        endcase
        if (rst_i) begin
            w_tmr_val = CNT_W'(C_PU);
        end
    end

    assign rdy_o      = (r_state == ST_IDLE);
    assign lcd_e_o    = (r_state == ST_PULSE);
    assign lcd_rs_o   = r_rs;
    assign lcd_data_o = r_data;

endmodule

// File: tb/tb_lcd16x2_ctrl.sv
// tb_lcd16x2_ctrl
// Bench for lcd16x2_ctrl at CLK_FREQ_HZ=3 MHz, POWERUP_US=100, which keeps
// the run short while exercising the ceil() rounding and the 1-cycle minimum.
// Derived cycle counts at 3 MHz:
//   T_SU = ceil(0.18)=1, T_PW = ceil(1.5)=2, T_H = ceil(0.06)=1
//   T_EXEC = 150, T_LONG = 6000, 4.1 ms = 12300, 100 us = 300, power-up = 300
// Busy time of a write = SU+PW+H+delay: 154 (normal) or 6004 (long).
// Init: 300 + 6*(INIT 1 + SU 1 + PW 2 + H 1) + (12300+300+150+150+6000+150)
//       = 19380 cycles from the last reset edge until rdy_o rises.
// Replay after reset: E rises after POWERUP 300 + INIT 1 + SETUP 1 -> 303rd cycle.
module tb_lcd16x2_ctrl;

    localparam int BUSY_EXEC   = 154;
    localparam int BUSY_LONG   = 6004;
    localparam int T_SU        = 1;
    localparam int T_PW        = 2;
    localparam int INIT_TOTAL  = 19380;
    localparam int REPLAY_RISE = 303;
    localparam int LIMIT       = 30000;

    typedef struct packed {
        logic       rs;
        logic [7:0] db;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] data_i;
    logic [1:0] ops_i;
    logic       enb_i;
    logic       rdy_o;
    logic       lcd_rs_o;
    logic       lcd_e_o;
    logic [7:0] lcd_data_o;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    lcd16x2_ctrl #(
        .CLK_FREQ_HZ (3_000_000),
        .POWERUP_US  (100)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .ops_i      (ops_i),
        .enb_i      (enb_i),
        .rdy_o      (rdy_o),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_e_o    (lcd_e_o),
        .lcd_data_o (lcd_data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        while (rdy_o !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_wait_rdy"}, int'(rdy_o), 1);
    endtask

    // One client write with the drop-enable handshake.
    task automatic issue(input logic [1:0] op, input logic [7:0] din, input logic exp_rs,
                         input logic [7:0] exp_db, input int exp_busy, input string tag);
        int n;
        int rise;
        wait_rdy(tag);
        exp_q.push_back({exp_rs, exp_db});
        ops_i  = op;
        data_i = din;
        enb_i  = 1'b1;
        tick();
        check({tag, "_rdy_fall"}, int'(rdy_o), 0);
        check({tag, "_rs"}, int'(lcd_rs_o), int'(exp_rs));
        check({tag, "_db"}, int'(lcd_data_o), int'(exp_db));
        // Busy-time input changes must not reach the bus.
        enb_i  = 1'b0;
        data_i = ~din;
        ops_i  = op ^ 2'd1;
        n    = 0;
        rise = -1;
        while (rdy_o == 1'b0 && n < LIMIT) begin
            n++;
            if (lcd_e_o && rise < 0) rise = n;
            tick();
        end
        check({tag, "_e_rise"}, rise, 1 + T_SU);
        check({tag, "_busy"}, n, exp_busy);
        check({tag, "_idle_db"}, int'(lcd_data_o), int'(exp_db));
        check({tag, "_idle_rs"}, int'(lcd_rs_o), int'(exp_rs));
    endtask

    // Scoreboard monitor: every E pulse pops one expectation.
    initial begin
        logic prev_e;
        logic aborted;
        int   width;
        exp_t e;
        prev_e  = 1'b0;
        aborted = 1'b0;
        width   = 0;
        forever begin
            @(negedge clk);
            if (lcd_e_o && !prev_e) begin
                width   = 1;
                aborted = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pulse_unexpected: got pulse rs=%0d db=0x%0h, expected none",
                             lcd_rs_o, lcd_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_rs", int'(lcd_rs_o), int'(e.rs));
                    check("pulse_db", int'(lcd_data_o), int'(e.db));
                end
            end else if (lcd_e_o) begin
                width++;
            end else if (prev_e && !aborted) begin
                check("pulse_width", width, T_PW);
            end
            if (lcd_e_o && rst_i) aborted = 1'b1;
            prev_e = lcd_e_o;
        end
    end

    initial begin
        logic [7:0] hello [11];
        int n;
        int len;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
        rst_i  = 1'b1;
        enb_i  = 1'b0;
        ops_i  = 2'd0;
        data_i = 8'h00;

        // Reset and init; a request held through init must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", int'(rdy_o), 0);
        check("reset_e", int'(lcd_e_o), 0);
        check("reset_rs", int'(lcd_rs_o), 0);
        check("reset_db", int'(lcd_data_o), 0);
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        rst_i  = 1'b0;
        enb_i  = 1'b1;
        ops_i  = 2'd1;
        data_i = 8'h55;
        n = 0;
        while (rdy_o !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
            if (n == 19370) enb_i = 1'b0;
        end
        enb_i = 1'b0;
        check("init_rdy_cycles", n, INIT_TOTAL);
        check("init_q_empty", exp_q.size(), 0);
        check("init_idle_db", int'(lcd_data_o), 8'h06);

        // Single writes, including delay-class boundaries.
        issue(2'd1, 8'h48, 1'b1, 8'h48, BUSY_EXEC, "char_H");
        issue(2'd2, 8'hFF, 1'b0, 8'h01, BUSY_LONG, "clear");
        issue(2'd3, 8'h77, 1'b0, 8'h02, BUSY_LONG, "home");
        issue(2'd0, 8'h03, 1'b0, 8'h03, BUSY_LONG, "cmd03");
        issue(2'd0, 8'h04, 1'b0, 8'h04, BUSY_EXEC, "cmd04");
        issue(2'd0, 8'h00, 1'b0, 8'h00, BUSY_EXEC, "cmd00");

        for (int i = 0; i < 11; i++) begin
            issue(2'd1, hello[i], 1'b1, hello[i], BUSY_EXEC, "hello");
        end
        check("hello_q_empty", exp_q.size(), 0);

        // Held enable: three back-to-back writes, one idle cycle between.
        wait_rdy("held");
        exp_q.push_back({1'b1, 8'h41});
        exp_q.push_back({1'b1, 8'h41});
        exp_q.push_back({1'b1, 8'h41});
        ops_i  = 2'd1;
        data_i = 8'h41;
        enb_i  = 1'b1;
        tick();
        for (int w = 0; w < 2; w++) begin
            n = 0;
            while (rdy_o == 1'b0 && n < LIMIT) begin
                tick();
                n++;
            end
            check("held_busy", n, BUSY_EXEC);
            len = 0;
            while (rdy_o == 1'b1 && len < 10) begin
                len++;
                tick();
            end
            check("held_rdy_len", len, 1);
        end
        enb_i = 1'b0;
        wait_rdy("held_end");
        repeat (3) tick();
        check("held_stays_idle", int'(rdy_o), 1);
        check("held_q_empty", exp_q.size(), 0);
        check("held_idle_db", int'(lcd_data_o), 8'h41);

        // Reset in the middle of an E pulse.
        wait_rdy("rmp");
        exp_q.push_back({1'b1, 8'h5A});
        ops_i  = 2'd1;
        data_i = 8'h5A;
        enb_i  = 1'b1;
        tick();
        enb_i = 1'b0;
        n = 0;
        while (lcd_e_o == 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("rmp_e_seen", int'(lcd_e_o), 1);
        rst_i = 1'b1;
        exp_q.push_back({1'b0, 8'h38});
        tick();
        check("rmp_e", int'(lcd_e_o), 0);
        check("rmp_rdy", int'(rdy_o), 0);
        check("rmp_rs", int'(lcd_rs_o), 0);
        check("rmp_db", int'(lcd_data_o), 0);
        rst_i = 1'b0;
        n = 1;
        while (lcd_e_o == 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        check("rmp_replay_rise", n, REPLAY_RISE);
        n = 0;
        while (lcd_e_o == 1'b1 && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("rmp_q_empty", exp_q.size(), 0);
        check("rmp_not_ready", int'(rdy_o), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
